// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the dmux_stream demultiplexer: slot state encoding
// and the saturating drop counter. The optional broadcast feature of the top
// level is enabled with the macro DMUX_STREAM_BROADCAST_EN.
package dmux_stream_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int                    DROP_CNT_W   = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] drop_cnt_inc(input logic [DROP_CNT_W-1:0] value);
        return (value == DROP_CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dmux_stream_slot.sv
// One-entry output register with a valid/ready handshake. A new word may be
// loaded while the current one drains on the same edge, so a single slot
// sustains one word per cycle.
module dmux_stream_slot
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             can_load,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
);

    slot_state_t state;
    slot_state_t state_next;

    // Slot state register; reset empties the slot immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a load always leaves the slot full, otherwise a
    // consumed word empties it.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end else if (ready) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Data register; keeps its last word while the slot is empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    assign valid    = (state == SLOT_FULL);
    assign can_load = (state == SLOT_EMPTY) || ready;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-CHANNELS stream demultiplexer. Each channel owns a
// one-entry slot, so a stalled consumer only blocks words addressed to it.
// Words addressed past the last channel are accepted, discarded and counted.
// Optional: define DMUX_STREAM_BROADCAST_EN to add a `broadcast` input that
// writes one word to every channel in a single transfer.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
`ifdef DMUX_STREAM_BROADCAST_EN
    input  logic                      broadcast,
`endif
    input  logic [SEL_W-1:0]          select,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [DROP_CNT_W-1:0]     drop_count
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0] can_load;
    logic [CHANNELS-1:0] load;
    logic                in_range;
    logic                bcast;
    logic                drop_hit;

`ifdef DMUX_STREAM_BROADCAST_EN
    assign bcast = broadcast;
`else
    assign bcast = 1'b0;
`endif

    assign in_range = ({1'b0, select} < CH_LIMIT);

    // Select decode and in_ready mux; in_ready is independent of in_valid.
    always_comb begin
        load     = '0;
        in_ready = 1'b1;
        drop_hit = 1'b0;
        if (bcast) begin
            in_ready = &can_load;
            load     = {CHANNELS{in_valid && (&can_load)}};
        end else if (in_range) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (select == SEL_W'(k)) begin
                    in_ready = can_load[k];
                    load[k]  = in_valid && can_load[k];
                end
            end
        end else begin
            drop_hit = in_valid;
        end
    end

    // Count discarded out-of-range words, saturating at the maximum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_hit) begin
            drop_count <= drop_cnt_inc(drop_count);
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        dmux_stream_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .load     (load[k]),
            .load_data(in_data),
            .can_load (can_load[k]),
            .data     (out_data[k*WIDTH +: WIDTH]),
            .valid    (out_valid[k]),
            .ready    (out_ready[k])
        );
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream with three channels, so that select = 3
// exercises the discard path. A reference model keeps one queue of pending
// words per channel; the issuer pushes accepted words, the monitor compares
// and pops whenever a channel presents a word.
module tb_dmux_stream;

    localparam int W  = 16;
    localparam int CH = 3;
    localparam int SW = 2;

    typedef logic [W-1:0] word_q_t[$];

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [W-1:0]    in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SW-1:0]   select = '0;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_ready = '0;
    logic [15:0]     drop_count;
`ifdef DMUX_STREAM_BROADCAST_EN
    logic            broadcast = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    word_q_t     mq[CH];
    logic [15:0] drop_m  = '0;
    logic        stalled = 1'b0;

    dmux_stream #(
        .WIDTH   (W),
        .CHANNELS(CH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef DMUX_STREAM_BROADCAST_EN
        .broadcast (broadcast),
`endif
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dat(input int k);
        return out_data[k*W +: W];
    endfunction

    function automatic logic is_bcast();
`ifdef DMUX_STREAM_BROADCAST_EN
        return broadcast;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < CH; k++) mq[k].delete();
        drop_m  = '0;
        stalled = 1'b0;
    endtask

    // Monitor: compare presented words against the model, pop consumed ones.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < CH; k++) begin
                check($sformatf("out_valid[%0d]", k), out_valid[k], mq[k].size() != 0);
                if (mq[k].size() != 0) begin
                    check($sformatf("out_data[%0d]", k), dat(k), mq[k][0]);
                end
            end
            check("drop_count", drop_count, drop_m);
            for (int k = 0; k < CH; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
            end
        end
    end

    // Issuer: after consumed words are popped, a channel can take a word
    // exactly when its queue is empty; record accepted words.
    always @(negedge clock) begin
        logic exp_rdy;
        #1;
        if (!reset) begin
            if (is_bcast()) begin
                exp_rdy = 1'b1;
                for (int k = 0; k < CH; k++) if (mq[k].size() != 0) exp_rdy = 1'b0;
            end else if (int'(select) >= CH) begin
                exp_rdy = 1'b1;
            end else begin
                exp_rdy = (mq[select].size() == 0);
            end
            check("in_ready", in_ready, exp_rdy);
            stalled = in_valid && !exp_rdy;
            if (in_valid && exp_rdy) begin
                if (is_bcast()) begin
                    for (int k = 0; k < CH; k++) mq[k].push_back(in_data);
                end else if (int'(select) >= CH) begin
                    if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
                end else begin
                    mq[select].push_back(in_data);
                end
            end
        end
    end

    initial begin
        // Reset state, visible before any clock edge.
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_out_data", out_data[31:0], 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        reset = 1'b0;

        // Basic route to channel 2.
        out_ready = 3'b111;
        in_data   = 16'hA5A5;
        select    = 2'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("route_valid", out_valid, 3'b100);
        check("route_data2", dat(2), 16'hA5A5);
        check("route_data0", dat(0), 16'h0000);
        check("route_data1", dat(1), 16'h0000);
        tick();

        // Backpressure on channel 1, then same-edge drain and refill.
        out_ready = 3'b101;
        in_data   = 16'h0001;
        select    = 2'd1;
        in_valid  = 1'b1;
        #1 check("bp_first_ready", in_ready, 1);
        tick();
        in_data = 16'h0002;
        #1 check("bp_stall_ready", in_ready, 0);
        tick();
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_data", dat(1), 16'h0001);
        check("bp_hold_valid", out_valid[1], 1);
        out_ready = 3'b111;
        #1 check("bp_release_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 3'b101;
        check("bp_refill_data", dat(1), 16'h0002);
        check("bp_refill_valid", out_valid[1], 1);

        // Independence: channel 1 stalled full, channel 2 still flows.
        in_data  = 16'h0003;
        select   = 2'd2;
        in_valid = 1'b1;
        #1 check("indep_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("indep_valid", out_valid, 3'b110);
        check("indep_data2", dat(2), 16'h0003);
        out_ready = 3'b111;
        tick();
        tick();
        check("drained", out_valid, 3'b000);

        // Out-of-range select: five words discarded and counted.
        select   = 2'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'($urandom);
            #1 check("drop_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        check("drop_valid", out_valid, 3'b000);
        check("drop_count5", drop_count, 5);

`ifdef DMUX_STREAM_BROADCAST_EN
        // Broadcast to all empty slots, then blocked by one stalled slot.
        in_data   = 16'h1234;
        broadcast = 1'b1;
        in_valid  = 1'b1;
        #1 check("bc_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bc_valid", out_valid, 3'b111);
        for (int k = 0; k < CH; k++) check($sformatf("bc_data%0d", k), dat(k), 16'h1234);
        out_ready = 3'b110;
        tick();
        in_data  = 16'h5678;
        in_valid = 1'b1;
        #1 check("bc_blocked", in_ready, 0);
        in_valid  = 1'b0;
        broadcast = 1'b0;
        out_ready = 3'b111;
        tick();
        tick();
        check("bc_drops", drop_count, 5);
`endif

        // Randomised traffic with held stimulus while stalled.
        repeat (3000) begin
            out_ready = CH'($urandom);
            if (!stalled) begin
                in_valid = ($urandom % 4) != 0;
                select   = SW'($urandom);
                in_data  = W'($urandom);
`ifdef DMUX_STREAM_BROADCAST_EN
                broadcast = ($urandom % 8) == 0;
`endif
            end
            tick();
        end
        in_valid = 1'b0;
`ifdef DMUX_STREAM_BROADCAST_EN
        broadcast = 1'b0;
`endif
        out_ready = 3'b111;
        tick();
        tick();

        // Reset mid-stream with slots 0 and 2 full.
        out_ready = 3'b000;
        select    = 2'd0;
        in_data   = 16'hAAAA;
        in_valid  = 1'b1;
        tick();
        select  = 2'd2;
        in_data = 16'hCCCC;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 3'b101);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 3'b000);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_data", out_data[31:0], 0);
        clear_model();
        tick();
        reset = 1'b0;

        // Drop counter saturation.
        out_ready = 3'b111;
        select    = 2'd3;
        in_valid  = 1'b1;
        repeat (65534) @(posedge clock);
        #1 check("drop_fffe", drop_count, 16'hFFFE);
        repeat (3) @(posedge clock);
        #1 check("drop_sat", drop_count, 16'hFFFF);
        in_valid = 1'b0;
        tick();
        check("drop_sat_hold", drop_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Registered, parametrised 1-to-N demultiplexer for data streams; the sequential successor of the combinational 1-bit dmux.
- Routes one valid/ready input word to one of CHANNELS output channels, selected by `select`.
- Each output channel holds a one-entry output register, so a stalled channel does not block traffic to other channels once its word has been delivered.
- Sits between a single producer (e.g. CPU bus write port) and multiple consumers (memory-mapped peripherals).

Parameters:
- WIDTH, 16, data word width in bits.
- CHANNELS, 4, number of output channels (>= 2).
- SEL_W, $clog2(CHANNELS), width of `select`; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word this cycle.
- select  input  SEL_W  target channel index; sampled with in_data.
- out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  CHANNELS  per-channel word present.
- out_ready  input  CHANNELS  per-channel consumer accepts the word.
- drop_count  output  16  count of words addressed to an out-of-range channel.

Behaviour:
- Reset (asynchronous, active-high): all out_valid = 0, out_data = 0, drop_count = 0. in_ready reflects the reset state combinationally.
- Per channel k, slot state is EMPTY or FULL; out_valid[k] is asserted exactly when the slot is FULL.
- Input handshake: transfer occurs when in_valid && in_ready on a rising edge.
- in_ready is combinational:
  - 1 if select >= CHANNELS (drop path);
  - else 1 if the slot for `select` is EMPTY, or FULL with out_ready[select] = 1 (same-cycle drain and refill).
- in_ready never depends on in_valid.
- Output handshake: slot k is emptied when out_valid[k] && out_ready[k].
- Transitions:
  - EMPTY -> FULL on input transfer to k;
  - FULL -> EMPTY on output transfer with no input to k;
  - FULL -> FULL with new data on simultaneous output and input transfer to k.
- Latency: a word accepted at edge n appears on out_data/out_valid after edge n. Throughput is 1 word/cycle per channel.
- Non-selected channels keep their data and valid unchanged. out_data[k] holds its last value when EMPTY; consumers must not rely on it.
- Out-of-range select (only possible when CHANNELS is not a power of 2): the word is accepted and discarded, and drop_count increments.
- drop_count saturates at 16'hFFFF; it does not wrap.
- Producer must hold in_data/select stable while in_valid && !in_ready.
- Reset asserted mid-operation clears all slots immediately. Words in flight are lost, with no partial outputs.

Optional Feature:
- Macro: DMUX_STREAM_BROADCAST_EN.
- When defined:
  - adds input port `broadcast` (1 bit);
  - when broadcast = 1, the word is written to every channel in a single transfer, and `select` is ignored;
  - in_ready = AND over all k of (slot k EMPTY or out_ready[k]);
  - drop_count is unaffected by broadcast transfers.
- When undefined: no `broadcast` port; behaviour exactly as above.

Decomposition:
- Package dmux_stream_pkg holds:
  - slot state encoding (SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1);
  - DROP_CNT_W = 16;
  - DROP_CNT_MAX constant.
- Sub-module dmux_stream_slot: one-entry register with valid/ready and load/drain logic, instantiated CHANNELS times via generate.
- The top level holds select decode, in_ready mux and drop counter.

Test Plan:
- Reset: assert reset mid-stream with slots 0 and 2 FULL -> out_valid = 4'b0000 immediately (before the next clock edge), drop_count = 0.
- Basic route: CHANNELS=4; in_data=16'hA5A5, select=2, in_valid=1, out_ready=4'b1111 -> one cycle later out_valid = 4'b0100 and channel 2 data = 16'hA5A5; other channels unchanged.
- Backpressure:
  - out_ready[1] = 0; send 16'h0001 then 16'h0002 to channel 1 -> first accepted, then in_ready = 0 holding 16'h0002;
  - raise out_ready[1] -> 16'h0001 drained and 16'h0002 loaded on the same edge.
- Independence: channel 1 stalled FULL; send 16'h0003 to channel 3 -> in_ready = 1 and it is delivered next cycle.
- Out of range: CHANNELS=3, select=3, 5 words -> all accepted, out_valid = 0, drop_count = 5; preload 16'hFFFE and drop 3 more -> drop_count = 16'hFFFF.
- Broadcast (DMUX_STREAM_BROADCAST_EN): broadcast=1, in_data=16'h1234, all slots EMPTY -> all out_valid set, every channel = 16'h1234; with one slot FULL and not ready -> in_ready = 0.
